// File: rtl/cs_seq_ctrl.sv
// Sequencing controller for the CS 9-sample window engine: handshake, warm-up fill,
// serial tap scan, result emission and flush. Optional result counter: CS_CTRL_EMIT_CNT_EN.
module cs_seq_ctrl #(
  parameter int WIN  = 9,
  parameter int TAPW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            win_shift,
  output logic [TAPW-1:0] tap_sel,
  output logic            scan_first,
  output logic            scan_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAPW-1:0] fill_cnt,
  output logic            busy,
  output logic [15:0]     emit_cnt
);

  localparam logic [TAPW-1:0] WIN_M1 = TAPW'(WIN - 1);
  localparam logic [TAPW-1:0] ONE    = TAPW'(1);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_SCAN, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic [TAPW-1:0] fill_cnt_q, fill_cnt_d;
  logic [TAPW-1:0] tap_sel_q, tap_sel_d;
  logic            out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    tap_sel_d   = tap_sel_q;
    out_valid_d = out_valid_q;
    // Sample acceptance is blocked while flushing so no sample slips into an emptied window.
    in_ready    = ~clr & ((state_q == S_FILL) | (state_q == S_WAIT));
    win_shift   = in_valid & in_ready;

    if (clr) begin
      state_d     = S_FILL;
      fill_cnt_d  = '0;
      tap_sel_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (win_shift) begin
            fill_cnt_d = fill_cnt_q + ONE;
            if (fill_cnt_q == WIN_M1) state_d = S_SCAN;
          end
        end
        S_WAIT: begin
          if (win_shift) state_d = S_SCAN;
        end
        S_SCAN: begin
          if (tap_sel_q == WIN_M1) begin
            state_d     = S_EMIT;
            tap_sel_d   = '0;
            out_valid_d = 1'b1;
          end else begin
            tap_sel_d = tap_sel_q + ONE;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            state_d     = S_WAIT;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_FILL;
          fill_cnt_d  = '0;
          tap_sel_d   = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FILL;
      fill_cnt_q  <= '0;
      tap_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      tap_sel_q   <= tap_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign tap_sel    = tap_sel_q;
  assign fill_cnt   = fill_cnt_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q == S_SCAN) | (state_q == S_EMIT);
  assign scan_first = (state_q == S_SCAN) & (tap_sel_q == '0);
  assign scan_last  = (state_q == S_SCAN) & (tap_sel_q == WIN_M1);

`ifdef CS_CTRL_EMIT_CNT_EN
  logic [15:0] emit_cnt_q, emit_cnt_d;

  // A flush in the handshake cycle discards the result, so it is not counted.
  always_comb begin
    emit_cnt_d = emit_cnt_q;
    if (out_valid_q & out_ready & ~clr) emit_cnt_d = emit_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) emit_cnt_q <= '0;
    else        emit_cnt_q <= emit_cnt_d;
  end

  assign emit_cnt = emit_cnt_q;
`else
  assign emit_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cs_seq_ctrl.sv
// Directed self-checking bench for cs_seq_ctrl (default build and CS_CTRL_EMIT_CNT_EN build).
`timescale 1ns/1ps
module tb_cs_seq_ctrl;

`ifdef CS_CTRL_EMIT_CNT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clr, in_valid, out_ready;
  logic        in_ready, win_shift, scan_first, scan_last, out_valid, busy;
  logic [3:0]  tap_sel, fill_cnt;
  logic [15:0] emit_cnt;

  int checks = 0;
  int failures = 0;

  cs_seq_ctrl #(.WIN(9), .TAPW(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .win_shift(win_shift), .tap_sel(tap_sel), .scan_first(scan_first), .scan_last(scan_last),
    .out_valid(out_valid), .out_ready(out_ready), .fill_cnt(fill_cnt), .busy(busy),
    .emit_cnt(emit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
    checks++; if (tap_sel !== 4'd0) begin failures++; $display("FAIL reset_tap got=%0d exp=0", tap_sel); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (emit_cnt !== 16'h0) begin failures++; $display("FAIL reset_emit got=%0h exp=0", emit_cnt); end
    reset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_warmup;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      checks++; if (win_shift !== 1'b1) begin failures++; $display("FAIL warm_shift[%0d] got=%b exp=1", i, win_shift); end
      checks++; if (fill_cnt !== 4'(i)) begin failures++; $display("FAIL warm_fill[%0d] got=%0d exp=%0d", i, fill_cnt, i); end
      tick();
    end
    checks++; if (fill_cnt !== 4'd9) begin failures++; $display("FAIL warm_fill_full got=%0d exp=9", fill_cnt); end
    for (int k = 0; k < 9; k++) begin
      checks++; if (tap_sel !== 4'(k)) begin failures++; $display("FAIL scan_tap[%0d] got=%0d exp=%0d", k, tap_sel, k); end
      checks++; if (scan_first !== (k == 0)) begin failures++; $display("FAIL scan_first[%0d] got=%b exp=%b", k, scan_first, (k == 0)); end
      checks++; if (scan_last !== (k == 8)) begin failures++; $display("FAIL scan_last[%0d] got=%b exp=%b", k, scan_last, (k == 8)); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL scan_in_ready[%0d] got=%b exp=0", k, in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL scan_out_valid[%0d] got=%b exp=0", k, out_valid); end
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL warm_latency out_valid got=%b exp=1", out_valid); end
    checks++; if (tap_sel !== 4'd0) begin failures++; $display("FAIL emit_tap got=%0d exp=0", tap_sel); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL warm_pulse_len got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL warm_wait_ready got=%b exp=1", in_ready); end
    checks++; if (fill_cnt !== 4'd9) begin failures++; $display("FAIL warm_wait_fill got=%0d exp=9", fill_cnt); end
  endtask

  task automatic test_stream;
    int acc = 0, res = 0, last = 0, bad_ready = 0, bad_int = 0, cyc = 0;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    while (cyc < 400 && !(acc == 20 && res == 12)) begin
      if (busy && in_ready) bad_ready++;
      if (win_shift) begin
        acc++;
        if (acc >= 10 && (cyc - last) != 11) bad_int++;
        last = cyc;
      end
      if (out_valid && out_ready) res++;
      tick();
      if (acc == 20) in_valid = 1'b0;
      cyc++;
    end
    checks++; if (acc != 20) begin failures++; $display("FAIL stream_accepts got=%0d exp=20", acc); end
    checks++; if (res != 12) begin failures++; $display("FAIL stream_results got=%0d exp=12", res); end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL stream_ready_while_busy got=%0d exp=0", bad_ready); end
    checks++; if (bad_int != 0) begin failures++; $display("FAIL stream_interval got=%0d bad exp=0", bad_int); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    #1;
    checks++; if (win_shift !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", win_shift); end
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (n != 9) begin failures++; $display("FAIL bp_latency got=%0d exp=9", n); end
    for (int j = 0; j < 5; j++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] got=%b exp=1", j, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", j, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold6 got=%b exp=1", out_valid); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_wait_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_wait_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush;
    int n = 0, seen = 0, bad = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (tap_sel != 4'd4 && n < 20) begin tick(); n++; end
    checks++; if (tap_sel !== 4'd4 || busy !== 1'b1) begin failures++; $display("FAIL flush_reach_tap4 got=%0d exp=4", tap_sel); end
    clr = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    checks++; if (win_shift !== 1'b0) begin failures++; $display("FAIL flush_win_shift got=%b exp=0", win_shift); end
    tick();
    clr = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL flush_fill got=%0d exp=0", fill_cnt); end
    checks++; if (tap_sel !== 4'd0) begin failures++; $display("FAIL flush_tap got=%0d exp=0", tap_sel); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_state busy=%b in_ready=%b exp=0,1", busy, in_ready); end
    repeat (15) begin if (out_valid) seen++; tick(); end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
    in_valid = 1'b1;
    repeat (8) tick();
    in_valid = 1'b0;
    repeat (15) begin if (busy || out_valid) bad++; tick(); end
    checks++; if (bad != 0) begin failures++; $display("FAIL flush_8_accepts_busy got=%0d exp=0", bad); end
    checks++; if (fill_cnt !== 4'd8) begin failures++; $display("FAIL flush_fill8 got=%0d exp=8", fill_cnt); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || fill_cnt !== 4'd9) begin failures++; $display("FAIL flush_9th_accept busy=%b fill=%0d exp=1,9", busy, fill_cnt); end
    repeat (12) tick();
  endtask

  task automatic test_emit_cnt;
    int res = 0, n = 0;
    logic [15:0] exp3;
    exp3 = FEAT ? 16'd3 : 16'd0;
    do_reset();
    checks++; if (emit_cnt !== 16'h0) begin failures++; $display("FAIL emit_after_reset got=%0h exp=0", emit_cnt); end
    in_valid = 1'b1; out_ready = 1'b1;
    while (res < 3 && n < 100) begin
      if (out_valid && out_ready) begin res++; if (res == 3) in_valid = 1'b0; end
      tick(); n++;
    end
    checks++; if (emit_cnt !== exp3) begin failures++; $display("FAIL emit_count3 got=%0h exp=%0h", emit_cnt, exp3); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (emit_cnt !== exp3) begin failures++; $display("FAIL emit_after_clr got=%0h exp=%0h", emit_cnt, exp3); end
    in_valid = 1'b1;
    repeat (9) tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL emit_pending got=%b exp=1", out_valid); end
    clr = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (emit_cnt !== exp3) begin failures++; $display("FAIL emit_discard got=%0h exp=%0h", emit_cnt, exp3); end
    checks++; if (out_valid !== 1'b0 || fill_cnt !== 4'd0) begin failures++; $display("FAIL emit_discard_state ov=%b fill=%0d exp=0,0", out_valid, fill_cnt); end
  endtask

  task automatic test_async_reset;
    int n = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (9) tick();
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_reach_emit got=%b exp=1", out_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    checks++; if (fill_cnt !== 4'd0) begin failures++; $display("FAIL arst_fill got=%0d exp=0", fill_cnt); end
    checks++; if (emit_cnt !== 16'h0) begin failures++; $display("FAIL arst_emit got=%0h exp=0", emit_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    #2;
    reset = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL arst_release in_ready=%b ov=%b exp=1,0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_stream();
    test_backpressure();
    test_flush();
    test_emit_cnt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cs_seq_ctrl.md
Name: cs_seq_ctrl

Overview:
- Sequencing controller for the 9-sample window datapath (CS engine: 8-bit samples X in, 10-bit result Y out).
- Owns the input handshake, window-fill warm-up, per-sample serial tap scan, result emission with backpressure, and flush.
- Drives only control strobes into the datapath. Carries no sample or result data.

Parameters:
- WIN, 9, window depth in samples; number of scan cycles per result.
- TAPW, 4, width of tap_sel and fill_cnt; must satisfy 2^TAPW > WIN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush; empties the window and aborts the scan.
- in_valid  input  1  upstream sample X valid.
- in_ready  output  1  controller accepts a sample this cycle.
- win_shift  output  1  datapath shifts X into the window (= in_valid & in_ready, combinational).
- tap_sel  output  TAPW  window tap compared by the datapath this cycle.
- scan_first  output  1  first scan cycle; datapath clears its search accumulator.
- scan_last  output  1  final scan cycle; datapath registers Y.
- out_valid  output  1  Y valid to downstream.
- out_ready  input  1  downstream accepts Y.
- fill_cnt  output  TAPW  samples held in the window, saturating at WIN.
- busy  output  1  state is SCAN or EMIT.
- emit_cnt  output  16  results delivered (optional feature).

Behaviour:
- Reset (reset low, asynchronous):
  - state = FILL, fill_cnt = 0, tap_sel = 0, out_valid = 0, emit_cnt = 0.
  - in_ready = 1 once reset is released.
- States:
  - FILL: in_ready = 1.
    - Each accept increments fill_cnt.
    - An accept with fill_cnt == WIN-1 goes to SCAN; otherwise stay in FILL.
  - WAIT: window full, in_ready = 1.
    - An accept goes to SCAN; fill_cnt stays WIN.
  - SCAN: in_ready = 0.
    - tap_sel steps 0,1,…,WIN-1 on consecutive cycles.
    - scan_first = 1 when tap_sel == 0; scan_last = 1 when tap_sel == WIN-1.
    - After the scan_last cycle, go to EMIT.
  - EMIT: out_valid = 1 (registered), in_ready = 0.
    - Hold until out_ready = 1; on out_valid & out_ready go to WAIT and clear out_valid.
- Latency:
  - Accept in cycle t → SCAN occupies t+1..t+WIN → out_valid rises at t+WIN+1.
  - With out_ready held high, out_valid lasts one cycle.
  - Minimum sample interval is WIN+2 cycles (accept, WIN scan cycles, EMIT).
- tap_sel returns to 0 outside SCAN. scan_first and scan_last are 0 outside SCAN.
- clr:
  - Highest priority in any state.
  - Next cycle: state = FILL, fill_cnt = 0, tap_sel = 0, out_valid = 0.
  - A result pending in EMIT is discarded and emit_cnt does not increment.
  - in_ready = 0 and win_shift = 0 in the cycle clr is high.
- Ignored inputs:
  - in_valid during SCAN or EMIT is ignored; upstream must hold it (valid-stay rule).
  - out_ready outside EMIT is ignored.
- Reset asserted mid-SCAN or mid-EMIT returns to the reset state immediately. No partial out_valid pulse.
- fill_cnt never exceeds WIN.
- busy = (state == SCAN) | (state == EMIT).

Optional Feature:
- Macro CS_CTRL_EMIT_CNT_EN.
- Defined: emit_cnt is a 16-bit counter.
  - Increments on each out_valid & out_ready.
  - Wraps 0xFFFF → 0x0000.
  - Cleared by reset only, not by clr.
- Undefined: emit_cnt is tied to 16'h0000 and no counter flops are inferred.

Test Plan:
- Warm-up: reset released, in_valid held 1, out_ready = 1.
  - win_shift pulses on 9 consecutive cycles; fill_cnt steps 1..9.
  - After the 9th accept, tap_sel steps 0..8 with scan_first at 0 and scan_last at 8.
  - out_valid rises exactly 10 cycles after the 9th accept.
- Steady stream: 20 samples with in_valid always 1 and out_ready = 1.
  - After warm-up, one accept every 11 cycles; 12 results total.
  - in_ready = 0 throughout every SCAN and EMIT.
- Backpressure: out_ready = 0 for 5 cycles after out_valid rises.
  - out_valid holds 6 cycles and in_ready stays 0.
  - On out_ready = 1 the state is WAIT next cycle and in_ready = 1.
- Flush mid-scan: clr asserted at tap_sel = 4.
  - Next cycle fill_cnt = 0, tap_sel = 0, out_valid never rises.
  - The next result requires 9 new accepts.
- Async reset during EMIT: reset driven low between clock edges.
  - out_valid, fill_cnt and emit_cnt drop to 0 immediately, without waiting for an edge.
- Feature on: 65537 results emitted.
  - emit_cnt reads 0x0001.
  - A clr afterwards leaves it at 0x0001.
  - With the macro off, emit_cnt stays 0x0000.
